// File: rtl/uart_tx_param_pkg.sv
// Shared types, LCR field positions and parity helpers for the parameterised UART transmitter.
// Imported by uart_tx_param (top) and uart_tx_fifo_param.
package uart_tx_param_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP1,
      STOP2
   } tx_state_t;

   localparam logic [2:0] PAR_ODD  = 3'b001;
   localparam logic [2:0] PAR_EVEN = 3'b011;
   localparam logic [2:0] PAR_ONE  = 3'b101;
   localparam logic [2:0] PAR_ZERO = 3'b111;

   localparam int LCR_WLS_LSB = 0;
   localparam int LCR_WLS_MSB = 1;
   localparam int LCR_STB     = 2;
   localparam int LCR_PAR_LSB = 3;
   localparam int LCR_PAR_MSB = 5;
   localparam int LCR_BRK     = 6;

   // Word-length code 0..3 selects 5..8 data bits.
   function automatic logic [7:0] word_mask(input logic [1:0] wls);
      case (wls)
         2'b00:   return 8'h1F;
         2'b01:   return 8'h3F;
         2'b10:   return 8'h7F;
         default: return 8'hFF;
      endcase
   endfunction

   // The data argument must already have its unused upper bits cleared.
   function automatic logic calc_parity(input logic [2:0] mode, input logic [7:0] data);
      case (mode)
         PAR_ODD:  return ~^data;
         PAR_EVEN: return ^data;
         PAR_ONE:  return 1'b1;
         default:  return 1'b0;
      endcase
   endfunction

   function automatic logic parity_en(input logic [2:0] mode);
      return (mode == PAR_ODD) || (mode == PAR_EVEN) || (mode == PAR_ONE) || (mode == PAR_ZERO);
   endfunction

endpackage

// File: rtl/uart_tx_fifo_param.sv
// Byte FIFO feeding the UART transmitter: show-ahead read data, single-cycle pop,
// overflow pulse when a push is dropped. FIFO_DEPTH must be a power of two.
module uart_tx_fifo_param #(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [7:0]       wdata,
   output logic [7:0]       rdata,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees a slot, so a push at full still lands.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // NOTE: the storage array has no reset; only pointers and count define validity,
   // which keeps the array mappable to plain RAM/flops without a reset tree.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push && full && !do_pop;
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: oversampled bit timing, 5..8 data bits, optional parity,
// 1/2 stop bits, break, TX FIFO. Define UART_TX_CTS_EN to gate frame starts on cts_n.
module uart_tx_param
   import uart_tx_param_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic [7:0]       PWDATA,
   input  logic             tx_fifo_push,
   input  logic [7:0]       LCR,
   input  logic             enable,
   input  logic             cts_n,
   output logic             tx_fifo_empty,
   output logic             tx_fifo_full,
   output logic [CNT_W-1:0] tx_fifo_count,
   output logic             tx_overflow,
   output logic             tx_done,
   output logic             busy,
   output logic             TXD
);

   localparam int                TICK_W    = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

   tx_state_t         state;
   logic [TICK_W-1:0] tick_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shift_buf;
   logic [5:0]        lcr_q;
   logic              par_q;
   logic              line_q;
   logic              brk_q;
   logic [7:0]        fifo_rdata;
   logic              cts_ok;
   logic              start_fire;
   logic              next_ready;
   logic              last_tick;
   logic              lcr_unused;

`ifdef UART_TX_CTS_EN
   assign cts_ok = !cts_n;
`else
   logic cts_unused;
   assign cts_ok     = 1'b1;
   assign cts_unused = cts_n;
`endif

   assign lcr_unused = LCR[7];
   assign next_ready = !tx_fifo_empty && !LCR[LCR_BRK] && cts_ok;
   assign start_fire = (state == IDLE) && enable && next_ready;
   assign last_tick  = enable && (tick_cnt == TICK_LAST);

   // Break overrides the FSM line level one edge after LCR[6] changes.
   assign TXD = line_q && !brk_q;

   uart_tx_fifo_param #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .CNT_W     (CNT_W)
   ) u_fifo (
      .clk     (PCLK),
      .rst_n   (PRESETn),
      .push    (tx_fifo_push),
      .pop     (start_fire),
      .wdata   (PWDATA),
      .rdata   (fifo_rdata),
      .empty   (tx_fifo_empty),
      .full    (tx_fifo_full),
      .count   (tx_fifo_count),
      .overflow(tx_overflow)
   );

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_idx   <= '0;
         shift_buf <= '0;
         lcr_q     <= '0;
         par_q     <= 1'b0;
         line_q    <= 1'b1;
         brk_q     <= 1'b0;
         busy      <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         brk_q   <= LCR[LCR_BRK];
         tx_done <= 1'b0;
         if (state != IDLE && enable) tick_cnt <= last_tick ? '0 : tick_cnt + TICK_W'(1);

         unique case (state)
            IDLE: begin
               if (start_fire) begin
                  state     <= START;
                  shift_buf <= fifo_rdata;
                  lcr_q     <= LCR[5:0];
                  par_q     <= calc_parity(LCR[LCR_PAR_MSB:LCR_PAR_LSB],
                                           fifo_rdata & word_mask(LCR[LCR_WLS_MSB:LCR_WLS_LSB]));
                  bit_idx   <= '0;
                  line_q    <= 1'b0;
                  busy      <= 1'b1;
               end else begin
                  busy <= 1'b0;
               end
            end
            START: begin
               if (last_tick) begin
                  state  <= DATA;
                  line_q <= shift_buf[0];
               end
            end
            DATA: begin
               if (last_tick) begin
                  // Last data index is word length - 1, i.e. {1, wls}.
                  if (bit_idx == {1'b1, lcr_q[LCR_WLS_MSB:LCR_WLS_LSB]}) begin
                     if (parity_en(lcr_q[LCR_PAR_MSB:LCR_PAR_LSB])) begin
                        state  <= PARITY;
                        line_q <= par_q;
                     end else begin
                        state  <= STOP1;
                        line_q <= 1'b1;
                     end
                  end else begin
                     bit_idx   <= bit_idx + 3'd1;
                     shift_buf <= shift_buf >> 1;
                     line_q    <= shift_buf[1];
                  end
               end
            end
            PARITY: begin
               if (last_tick) begin
                  state  <= STOP1;
                  line_q <= 1'b1;
               end
            end
            STOP1: begin
               if (last_tick) begin
                  line_q <= 1'b1;
                  if (lcr_q[LCR_STB]) begin
                     state <= STOP2;
                  end else begin
                     state   <= IDLE;
                     tx_done <= 1'b1;
                     busy    <= next_ready;
                  end
               end
            end
            STOP2: begin
               if (last_tick) begin
                  state   <= IDLE;
                  line_q  <= 1'b1;
                  tx_done <= 1'b1;
                  busy    <= next_ready;
               end
            end
            default: begin
               state  <= IDLE;
               line_q <= 1'b1;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
